// File: rtl/bit_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bit_stream_pkg
//  Description : Shared types and constants for the bit stream serializer.
//                Holds the serializer FSM state enum and the default idle
//                level of the serial output. The PARITY state exists only
//                when SER_PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package bit_stream_pkg;

  // Level driven on serial_out while no word is in flight.
  localparam logic C_IDLE_VALUE = 1'b1;

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } ser_state_t;
`else
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/bit_stream_ser_if.sv
`default_nettype none
// ============================================================================
//  Module      : bit_stream_ser_if
//  Description : Parallel-in / serial-out handshake bundle.
//                master : word source (drives data_in, data_valid)
//                slave  : serializer (drives data_ready, serial_out, busy,
//                         word_done)
//  Parameters  : DATA_WIDTH - parallel word width
//  Revision    : 1.0 - initial release
// ============================================================================
interface bit_stream_ser_if #(
  parameter int DATA_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  data_ready;
  logic                  serial_out;
  logic                  busy;
  logic                  word_done;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  serial_out,
    input  busy,
    input  word_done
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output serial_out,
    output busy,
    output word_done
  );
endinterface
`default_nettype wire

// File: rtl/bit_stream_ser_sr.sv
`default_nettype none
// ============================================================================
//  Module      : flex_pts_sr
//  Description : Loadable MSB-first parallel-to-serial shift register.
//                load has priority over shift; zeros fill from the LSB.
//  Ports       : clk, rst (async, active-high), load, shift,
//                din[WIDTH-1:0] parallel word, msb_out current serial bit
//  Parameters  : WIDTH - register width (>= 2)
//  Revision    : 1.0 - initial release
// ============================================================================
module flex_pts_sr #(
  parameter int WIDTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load,
  input  wire logic             shift,
  input  wire logic [WIDTH-1:0] din,
  output logic                  msb_out
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = din;
    end else if (shift) begin
      data_d = {data_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign msb_out = data_q[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/bit_stream_ser.sv
`default_nettype none
// ============================================================================
//  Module      : bit_stream_ser
//  Description : Serializes DATA_WIDTH-bit words MSB first onto serial_out
//                with a valid/ready handshake. Back-to-back words stream
//                without idle gaps. Optional even-parity bit after the LSB
//                when the macro SER_PARITY_EN is defined.
//  Ports       : clk  - system clock
//                rst  - asynchronous active-high reset
//                bus  - bit_stream_ser_if.slave (data_in, data_valid,
//                       data_ready, serial_out, busy, word_done)
//  Parameters  : DATA_WIDTH (2..32), IDLE_VALUE
//  Revision    : 1.0 - initial release
// ============================================================================
import bit_stream_pkg::*;

module bit_stream_ser #(
  parameter int   DATA_WIDTH = 4,
  parameter logic IDLE_VALUE = C_IDLE_VALUE
) (
  input  wire logic          clk,
  input  wire logic          rst,
  bit_stream_ser_if.slave    bus
);

  localparam int                IDX_W  = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0]  C_LAST = IDX_W'(DATA_WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             w_load;
  logic             w_shift;
  logic             w_sr_bit;
  logic             w_last;
  logic             w_ready;
  logic             w_accept;

`ifdef SER_PARITY_EN
  logic parity_q, parity_d;
`endif

  flex_pts_sr #(
    .WIDTH (DATA_WIDTH)
  ) u_sr (
    .clk     (clk),
    .rst     (rst),
    .load    (w_load),
    .shift   (w_shift),
    .din     (bus.data_in),
    .msb_out (w_sr_bit)
  );

  // Final cycle of a word: this is where the next word may be taken.
`ifdef SER_PARITY_EN
  assign w_last = (state_q == ST_PARITY);
`else
  assign w_last = (state_q == ST_SHIFT) && (index_q == C_LAST);
`endif

  assign w_ready  = (state_q == ST_IDLE) || w_last;
  assign w_accept = bus.data_valid && w_ready;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    w_load  = 1'b0;
    w_shift = 1'b0;
`ifdef SER_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          state_d = ST_SHIFT;
          index_d = '0;
          w_load  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (index_q == C_LAST) begin
          index_d = '0;
`ifdef SER_PARITY_EN
          state_d = ST_PARITY;
`else
          if (w_accept) begin
            state_d = ST_SHIFT;
            w_load  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
`endif
        end else begin
          index_d = index_q + 1'b1;
          w_shift = 1'b1;
        end
      end
`ifdef SER_PARITY_EN
      ST_PARITY: begin
        if (w_accept) begin
          state_d = ST_SHIFT;
          index_d = '0;
          w_load  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        index_d = '0;
      end
    endcase
`ifdef SER_PARITY_EN
    // Parity is fixed at capture so later data_in changes cannot leak in.
    if (w_load) begin
      parity_d = ^bus.data_in;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      index_q <= '0;
`ifdef SER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      index_q <= index_d;
`ifdef SER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Outputs decode registered state only, so reset forces them at once.
  always_comb begin
    bus.serial_out = IDLE_VALUE;
    case (state_q)
      ST_SHIFT:  bus.serial_out = w_sr_bit;
`ifdef SER_PARITY_EN
      ST_PARITY: bus.serial_out = parity_q;
`endif
      default:   bus.serial_out = IDLE_VALUE;
    endcase
  end

  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.data_ready = w_ready;
  assign bus.word_done  = w_last;

endmodule
`default_nettype wire

// File: tb/tb_bit_stream_ser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_stream_ser
//  Description : Self-checking bench for bit_stream_ser (DATA_WIDTH=4,
//                IDLE_VALUE=1). Table of per-cycle vectors plus hand-written
//                sequences for async reset and a downstream 1101 detector.
//                Tables follow SER_PARITY_EN when it is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_stream_ser;

  typedef struct packed {
    logic       valid;
    logic [3:0] data;
    logic       so;
    logic       busy;
    logic       ready;
    logic       done;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [3:0] hist;
  logic       det;
  vec_t tbl[$];

  bit_stream_ser_if #(.DATA_WIDTH(4)) bus ();

  bit_stream_ser #(
    .DATA_WIDTH (4),
    .IDLE_VALUE (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Moore-style 1101 detector fed by the serial stream.
  always @(posedge clk or posedge rst) begin
    if (rst) hist <= 4'b0000;
    else     hist <= {hist[2:0], bus.serial_out};
  end
  assign det = (hist == 4'b1101);

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic so, input logic bsy,
                          input logic rdy, input logic dn);
    chk({tag, " serial_out"}, bus.serial_out, so);
    chk({tag, " busy"},       bus.busy,       bsy);
    chk({tag, " data_ready"}, bus.data_ready, rdy);
    chk({tag, " word_done"},  bus.word_done,  dn);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.data_valid = 1'b0;
    bus.data_in    = 4'b0000;

    //                valid data     so busy rdy done
`ifdef SER_PARITY_EN
    tbl.push_back({1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back({1'b1, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back({1'b1, 4'b1001, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back({1'b1, 4'b1001, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back({1'b1, 4'b1001, 1'b1, 1'b1, 1'b1, 1'b1});
    tbl.push_back({1'b1, 4'b1001, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back({1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back({1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back({1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back({1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1});
    tbl.push_back({1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0});
`else
    // Single word 1011
    tbl.push_back({1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back({1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back({1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back({1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1});
    tbl.push_back({1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0});
    // Back-to-back 1101 then 0011, valid held
    tbl.push_back({1'b1, 4'b1101, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back({1'b1, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back({1'b1, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back({1'b1, 4'b0011, 1'b1, 1'b1, 1'b1, 1'b1});
    tbl.push_back({1'b1, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back({1'b0, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back({1'b0, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back({1'b0, 4'b0011, 1'b1, 1'b1, 1'b1, 1'b1});
    tbl.push_back({1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0});
    // Hold: 0110 waits while 1001 is in flight, data_in churns later
    tbl.push_back({1'b1, 4'b1001, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back({1'b1, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back({1'b1, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back({1'b1, 4'b0110, 1'b1, 1'b1, 1'b1, 1'b1});
    tbl.push_back({1'b1, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back({1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back({1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back({1'b0, 4'b1001, 1'b0, 1'b1, 1'b1, 1'b1});
    tbl.push_back({1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0});
`endif

    // Reset state, checked while rst is held
    #12;
    chk_outs("reset", 1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;

    // First vector is accepted on the first edge with rst low
    for (int i = 0; i < tbl.size(); i++) begin
      bus.data_valid = tbl[i].valid;
      bus.data_in    = tbl[i].data;
      step();
      chk_outs($sformatf("vec%0d", i), tbl[i].so, tbl[i].busy,
               tbl[i].ready, tbl[i].done);
    end

    // Asynchronous reset mid-word
    bus.data_valid = 1'b1;
    bus.data_in    = 4'b1011;
    step();
    bus.data_valid = 1'b0;
    step();
    chk("midword serial_out", bus.serial_out, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_outs("async_rst", 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.data_valid = 1'b1;
    bus.data_in    = 4'b0100;
    step();
    chk_outs("post_rst_accept", 1'b0, 1'b1, 1'b0, 1'b0);
    bus.data_valid = 1'b0;
    step();
    chk("post_rst bit1", bus.serial_out, 1'b1);
    repeat (5) step();
    chk("post_rst idle busy", bus.busy, 1'b0);

    // Downstream 1101 detector
    bus.data_valid = 1'b1;
    bus.data_in    = 4'b1101;
    step();
    bus.data_valid = 1'b0;
    bus.data_in    = 4'b0000;
    step();
    step();
    step();
    chk("detector before last bit", det, 1'b0);
    step();
    chk("detector after 1101", det, 1'b1);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bit_stream_ser.md
BIT_STREAM_SER -- requirements
Module: bit_stream_ser

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 4: parallel word width in bits, legal range 2 to 32.
REQ-002 The block SHALL have parameter IDLE_VALUE, default 1'b1: serial_out level when no word is being sent.
REQ-003 The block SHALL have a single clock and an asynchronous, active-high reset; no other clocks or resets exist.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 data_in  input  DATA_WIDTH  parallel word to serialize, sent MSB first.
REQ-007 data_valid  input  1  data_in holds a valid word.
REQ-008 data_ready  output  1  block can accept a word at the next rising edge.
REQ-009 serial_out  output  1  serial bit stream feeding the downstream sequence detector input.
REQ-010 busy  output  1  a word (or its parity bit) is currently on serial_out.
REQ-011 word_done  output  1  one-cycle pulse while the final bit of a word is on serial_out.

Function
REQ-012 A word SHALL be accepted only on a rising edge where data_valid and data_ready are both 1; data_in is captured at that edge.
REQ-013 FSM states SHALL be IDLE and SHIFT, plus PARITY when SER_PARITY_EN is defined.
REQ-014 IDLE: data_ready=1, busy=0, serial_out=IDLE_VALUE; accept -> SHIFT with bit index 0.
REQ-015 SHIFT: serial_out=captured bit [DATA_WIDTH-1-index], busy=1; index increments each edge.
REQ-016 Latency: the MSB SHALL appear on serial_out in the cycle right after the accept edge, and each following bit SHALL appear one cycle later, with no gaps.
REQ-017 data_ready SHALL be 1 in the final cycle of a word (last SHIFT bit, or PARITY when enabled) and 0 in every other SHIFT cycle.
REQ-018 An accept in the final cycle SHALL go directly to SHIFT index 0, so back-to-back words are sent with no IDLE_VALUE cycle between them.
REQ-019 With no accept in the final cycle, the next state SHALL be IDLE.
REQ-020 data_valid while data_ready=0 SHALL be ignored; the source holds the word until accepted.
REQ-021 Changes on data_in after the accept edge SHALL NOT affect the word in flight.
REQ-022 serial_out, busy, data_ready and word_done SHALL be decoded from registered state only, with no combinational path from data_in or data_valid.
REQ-023 The bit index counter SHALL be $clog2(DATA_WIDTH) bits wide and SHALL wrap to 0 on the final bit.

Reset
REQ-024 While rst=1: state=IDLE, captured word=0, index=0, serial_out=IDLE_VALUE, data_ready=1, busy=0, word_done=0.
REQ-025 Reset asserted mid-word SHALL discard the word immediately (asynchronously); no partial resume after release.
REQ-026 The first accept after reset SHALL be possible on the first rising edge at which rst=0.

Configuration
REQ-027 Macro SER_PARITY_EN defined: after the LSB, one PARITY cycle SHALL output even parity (XOR of all captured bits); word length becomes DATA_WIDTH+1 cycles, and word_done/data_ready move to the PARITY cycle.
REQ-028 Macro SER_PARITY_EN undefined: the PARITY state and its logic SHALL NOT exist, and a word is exactly DATA_WIDTH cycles.

Structure
REQ-029 Package bit_stream_pkg SHALL hold the FSM state enum typedef and the default IDLE_VALUE constant.
REQ-030 Sub-module flex_pts_sr SHALL implement the loadable, MSB-first, parallel-to-serial shift register, parameterised by width.
REQ-031 bit_stream_ser SHALL contain the FSM, the bit index counter and the parity logic.

Verification (DATA_WIDTH=4, IDLE_VALUE=1)
REQ-032 Reset: rst=1 mid-stream -> serial_out=1, busy=0 and data_ready=1 within the same cycle, before any clock edge.
REQ-033 Single word 4'b1011 -> serial_out 1,0,1,1 then 1 (idle); word_done high only on the 4th bit; 4 busy cycles.
REQ-034 Back-to-back 4'b1101 then 4'b0011, valid held -> 1,1,0,1,0,0,1,1 contiguous; data_ready high only in cycles 4 and 8.
REQ-035 Hold: data_valid=1 with 4'b0110 while busy, data_in changing after accept -> the in-flight word is unchanged and the held word is accepted only in the final cycle.
REQ-036 SER_PARITY_EN defined: 4'b1011 -> 1,0,1,1,1; 4'b1001 -> 1,0,0,1,0; word_done on the parity cycle.
REQ-037 Downstream integration: stream 4'b1101 into the moore sequence detector -> detector output matches its expected sequence with no idle gap effects.
